// File: rtl/lcd_rgb_timing_gen.sv
// RGB parallel-panel timing generator: waits for the initializer's done pulse,
// then free-runs HSYNC/VSYNC/DE and drives requested pixels one cycle later.
module lcd_rgb_timing_gen #(
    parameter int H_SYNC   = 10,
    parameter int H_BACK   = 20,
    parameter int H_ACTIVE = 480,
    parameter int H_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 10,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter bit SYNC_POL = 1'b0,
    parameter int RGB_W    = 16,
    parameter int CNT_W    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init_done,
    input  logic [RGB_W-1:0] pix_data,
    output logic             data_req,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             frame_start,
    output logic             running,
    output logic             lcd_hsync,
    output logic             lcd_vsync,
    output logic             lcd_de,
    output logic [RGB_W-1:0] lcd_rgb
);
    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_START = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] H_END   = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_START = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SW    = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SW    = CNT_W'(V_SYNC);

    typedef enum logic {WAIT_INIT, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic               data_req_q, data_req_d, frame_start_q, frame_start_d;
    logic [CNT_W-1:0]   pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic               hs1_q, hs1_d, vs1_q, vs1_d;
    logic               lcd_hsync_q, lcd_hsync_d, lcd_vsync_q, lcd_vsync_d;
    logic               lcd_de_q, lcd_de_d;
    logic [RGB_W-1:0]   lcd_rgb_q, lcd_rgb_d;
    logic               run, h_act, v_act;

    assign run   = (state_q == RUN);
    assign h_act = (h_cnt_q >= H_START) && (h_cnt_q < H_END);
    assign v_act = (v_cnt_q >= V_START) && (v_cnt_q < V_END);

    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        case (state_q)
            WAIT_INIT: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (init_done) state_d = RUN;
            end
            RUN: begin
                if (h_cnt_q == H_LAST) begin
                    h_cnt_d = '0;
                    v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
                end else begin
                    h_cnt_d = h_cnt_q + 1'b1;
                end
            end
            default: state_d = WAIT_INIT;
        endcase

        // Stage 1: decode the current count; sync flags carried as "active" bits
        data_req_d    = run && h_act && v_act;
        pix_x_d       = data_req_d ? h_cnt_q - H_START : '0;
        pix_y_d       = data_req_d ? v_cnt_q - V_START : '0;
        frame_start_d = run && (h_cnt_q == '0) && (v_cnt_q == '0);
        hs1_d         = run && (h_cnt_q < H_SW);
        vs1_d         = run && (v_cnt_q < V_SW);

        // Stage 2: pixel captured in the request cycle lands with DE
        lcd_hsync_d = hs1_q ? SYNC_POL : ~SYNC_POL;
        lcd_vsync_d = vs1_q ? SYNC_POL : ~SYNC_POL;
        lcd_de_d    = data_req_q;
        lcd_rgb_d   = data_req_q ? pix_data : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= WAIT_INIT;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            data_req_q    <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            hs1_q         <= 1'b0;
            vs1_q         <= 1'b0;
            lcd_hsync_q   <= ~SYNC_POL;
            lcd_vsync_q   <= ~SYNC_POL;
            lcd_de_q      <= 1'b0;
            lcd_rgb_q     <= '0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            data_req_q    <= data_req_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
            hs1_q         <= hs1_d;
            vs1_q         <= vs1_d;
            lcd_hsync_q   <= lcd_hsync_d;
            lcd_vsync_q   <= lcd_vsync_d;
            lcd_de_q      <= lcd_de_d;
            lcd_rgb_q     <= lcd_rgb_d;
        end
    end

    assign running     = run;
    assign data_req    = data_req_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;
    assign lcd_hsync   = lcd_hsync_q;
    assign lcd_vsync   = lcd_vsync_q;
    assign lcd_de      = lcd_de_q;
    assign lcd_rgb     = lcd_rgb_q;
endmodule

// File: tb/tb_lcd_rgb_timing_gen.sv
// Bench for lcd_rgb_timing_gen on a tiny 10x7 raster; expectations come from
// cycles-since-start arithmetic rather than counters.
module tb_lcd_rgb_timing_gen;
    localparam int HS = 2, HB = 3, HA = 4, HF = 1;
    localparam int VS = 1, VB = 2, VA = 3, VF = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done = 1'b0;
    logic [15:0] pix_data = '0;
    logic        data_req, frame_start, running, lcd_hsync, lcd_vsync, lcd_de;
    logic [11:0] pix_x, pix_y;
    logic [15:0] lcd_rgb;

    lcd_rgb_timing_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
        .SYNC_POL(1'b0), .RGB_W(16), .CNT_W(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done), .pix_data(pix_data),
        .data_req(data_req), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .running(running),
        .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
        .lcd_rgb(lcd_rgb)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: m_k = cycles since the RUN entry edge; raster position at k is k mod FT.
    bit          m_run = 1'b0;
    int          m_k   = 0;
    logic [15:0] m_rgb = '0;
    bit          xy_mode = 1'b0;
    logic [15:0] rgb_log[$];

    function automatic int hpos(int k); return (k % FT) % HT; endfunction
    function automatic int vpos(int k); return (k % FT) / HT; endfunction
    function automatic bit act(int k);
        return hpos(k) >= HS + HB && hpos(k) < HS + HB + HA &&
               vpos(k) >= VS + VB && vpos(k) < VS + VB + VA;
    endfunction
    function automatic bit e_req(); return m_run && m_k >= 1 && act(m_k - 1); endfunction
    function automatic int e_x(); return e_req() ? hpos(m_k - 1) - (HS + HB) : 0; endfunction
    function automatic int e_y(); return e_req() ? vpos(m_k - 1) - (VS + VB) : 0; endfunction
    function automatic bit e_de(); return m_run && m_k >= 2 && act(m_k - 2); endfunction

    task automatic check_all();
        chk("running", 32'(running), 32'(m_run));
        chk("data_req", 32'(data_req), 32'(e_req()));
        chk("pix_x", 32'(pix_x), 32'(e_x()));
        chk("pix_y", 32'(pix_y), 32'(e_y()));
        chk("frame_start", 32'(frame_start),
            32'(m_run && m_k >= 1 && ((m_k - 1) % FT) == 0));
        chk("hsync", 32'(lcd_hsync), 32'(!(m_run && m_k >= 2 && hpos(m_k - 2) < HS)));
        chk("vsync", 32'(lcd_vsync), 32'(!(m_run && m_k >= 2 && vpos(m_k - 2) < VS)));
        chk("de", 32'(lcd_de), 32'(e_de()));
        chk("rgb", 32'(lcd_rgb), 32'(m_rgb));
    endtask

    // Advance one clock with the currently driven inputs, update model, check.
    task automatic step();
        bit req_now;
        req_now = e_req();
        @(posedge clk);
        if (!rst_n) begin
            m_run = 1'b0; m_k = 0; m_rgb = '0;
        end else if (!m_run) begin
            if (init_done) begin m_run = 1'b1; m_k = 0; end
            m_rgb = '0;
        end else begin
            m_rgb = req_now ? pix_data : 16'h0;
            m_k++;
        end
        #1;
        check_all();
        if (lcd_de) rgb_log.push_back(lcd_rgb);
        pix_data = xy_mode ? {8'(e_y()), 8'(e_x())} : 16'($urandom);
    endtask

    task automatic pulse_init();
        init_done = 1'b1; step(); init_done = 1'b0;
    endtask

    initial begin
        bit hit;
        // Reset, including init_done coinciding with reset
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            init_done = (i == 3);
            step();
        end
        init_done = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) step();

        // Three frames with {y,x} pixel pattern and an ignored extra init_done
        xy_mode = 1'b1;
        pix_data = '0;
        rgb_log.delete();
        pulse_init();
        for (int i = 0; i < 3 * FT + 5; i++) begin
            init_done = (i == 100);
            step();
        end
        init_done = 1'b0;
        chk("rgb_cnt", 32'(rgb_log.size()), 32'(3 * HA * VA));
        if (rgb_log.size() >= 12) begin
            for (int i = 0; i < 4; i++) begin
                chk("rgb_line0", 32'(rgb_log[i]), 32'(i));
                chk("rgb_line2", 32'(rgb_log[8 + i]), 32'(16'h0200 + i));
            end
        end

        // Reset on the 3rd active pixel, then restart
        hit = 1'b0;
        for (int i = 0; i < 2 * FT && !hit; i++) begin
            if (data_req && pix_x == 12'd2) hit = 1'b1;
            else step();
        end
        chk("third_px_found", 32'(hit), 32'(1));
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step();
        pulse_init();
        for (int i = 0; i < FT + 10; i++) step();

        // Random resets, init pulses and pixel data
        xy_mode = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst_n     = ($urandom_range(0, 499) != 0);
            init_done = ($urandom_range(0, 49) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lcd_rgb_timing_gen.md
Name: lcd_rgb_timing_gen

Overview:
- Downstream neighbour of the LCD SPI initializer.
- Stays idle until the panel initialization sequence completes, then free-runs the RGB parallel-interface video timing: HSYNC, VSYNC, DE and pixel data.
- Requests pixels from a frame source one cycle ahead and drives them, registered, onto the panel bus, aligned with DE.

Parameters:
- H_SYNC, 10, HSYNC pulse width in clk cycles
- H_BACK, 20, horizontal back porch in cycles
- H_ACTIVE, 480, active pixels per line
- H_FRONT, 10, horizontal front porch in cycles
- V_SYNC, 2, VSYNC pulse width in lines
- V_BACK, 10, vertical back porch in lines
- V_ACTIVE, 480, active lines per frame
- V_FRONT, 10, vertical front porch in lines
- SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high)
- RGB_W, 16, pixel data width (RGB565)
- CNT_W, 12, width of the h/v counters and of pix_x/pix_y

Ports:
- clk  input  1  pixel clock; single clock domain
- rst_n  input  1  synchronous active-low reset
- init_done  input  1  one-cycle pulse from the initializer, already synchronized into clk
- pix_data  input  RGB_W  pixel from the frame source; sampled in the cycle data_req=1
- data_req  output  1  pixel request; pix_x/pix_y valid in the same cycle
- pix_x  output  CNT_W  column of the requested pixel, 0..H_ACTIVE-1
- pix_y  output  CNT_W  row of the requested pixel, 0..V_ACTIVE-1
- frame_start  output  1  one-cycle pulse at h=0, v=0 of every frame
- running  output  1  high once timing generation has started
- lcd_hsync  output  1  panel HSYNC
- lcd_vsync  output  1  panel VSYNC
- lcd_de  output  1  panel data enable
- lcd_rgb  output  RGB_W  panel pixel bus

Behaviour:
- Reset is synchronous and active-low; the clock is clk, the reset is rst_n.
- Reset values: state=WAIT_INIT, h_cnt=v_cnt=0, data_req=0, pix_x=pix_y=0, frame_start=0, running=0, lcd_de=0, lcd_rgb=0, lcd_hsync=lcd_vsync=~SYNC_POL (inactive).
- Totals: H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT; V_TOTAL = V_SYNC+V_BACK+V_ACTIVE+V_FRONT.
- FSM WAIT_INIT:
  - counters held at 0, all outputs at reset values;
  - an init_done pulse moves the FSM to RUN on the next edge.
- FSM RUN:
  - h_cnt increments every cycle and wraps from H_TOTAL-1 to 0;
  - v_cnt increments on that h wrap and itself wraps from V_TOTAL-1 to 0;
  - running=1.
- RUN is left only by reset. Further init_done pulses in RUN are ignored.
- Stage 1 (registered from the counters; 1 cycle after the count):
  - h_act = H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE;
  - v_act is defined the same way on v_cnt;
  - data_req = h_act & v_act;
  - pix_x = h_cnt-(H_SYNC+H_BACK) and pix_y = v_cnt-(V_SYNC+V_BACK) when data_req=1, else 0;
  - frame_start = (h_cnt==0 & v_cnt==0).
- Stage 2 (registered from stage 1; 2 cycles after the count):
  - lcd_hsync = SYNC_POL when h_cnt<H_SYNC, delayed to stay aligned;
  - lcd_vsync = SYNC_POL when v_cnt<V_SYNC, asserted for whole lines and aligned with the line start;
  - lcd_de = the stage-1 data_req;
  - lcd_rgb = pix_data sampled in the data_req cycle, else 0.
- The first frame_start occurs in the cycle after entry to RUN. The first lcd_hsync/lcd_vsync assertion follows one cycle later.
- The pixel source must present pix_data combinationally (or pre-fetched) in the same cycle as data_req. Request-to-bus latency is exactly 1 cycle.
- init_done in the same cycle as rst_n=0: reset wins, state stays WAIT_INIT.
- Reset mid-frame: all outputs return to their reset values on the next edge, and the block waits for a new init_done.

Test Plan:
- Reset values: hold rst_n=0 for 5 cycles with SYNC_POL=0 -> hsync=vsync=1, de=0, rgb=0, running=0, data_req=0.
- Idle without start: no init_done for 200 cycles -> outputs stay at reset values, no frame_start.
- Line timing:
  - setup: H_SYNC=2, H_BACK=3, H_ACTIVE=4, H_FRONT=1, V_SYNC=1, V_BACK=2, V_ACTIVE=3, V_FRONT=1;
  - stimulus: pulse init_done;
  - hsync low for 2 of every 10 cycles;
  - vsync low for 10 of every 70 cycles;
  - frame_start period 70 cycles;
  - de high 4 cycles per active line, 12 cycles per frame.
- Pixel path: pix_data = {pix_y[7:0], pix_x[7:0]} -> lcd_rgb shows 0x0000, 0x0001, 0x0002, 0x0003 one cycle after each data_req (line 0); 0x0200..0x0203 on line 2.
- Wrap: run 3 frames -> pix_x sequence 0..3 per line, pix_y 0..2 per frame, no DE outside active lines, and frame_start coincides with h=0, v=0.
- Reset mid-frame plus re-start:
  - stimulus: assert rst_n=0 on the 3rd active pixel, then release;
  - response: outputs return to reset values on the next edge;
  - a second init_done in RUN has no effect on the period;
  - a new init_done after reset restarts timing from frame_start.
